// File: rtl/mcdf_arb_pkg.sv
// mcdf_arb_pkg: shared widths, FSM state type and packet-length decode for the MCDF packet arbiter
package mcdf_arb_pkg;
  localparam int DATA_W     = 32;
  localparam int CH_N       = 3;
  localparam int ID_W       = 2;
  localparam int PRIO_W     = 2;
  localparam int LEN_CODE_W = 3;
  localparam int LEN_W      = 6;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  // codes 0..3 give 4/8/16/32 words; every larger code saturates at 32
  function automatic logic [LEN_W-1:0] len_decode(input logic [LEN_CODE_W-1:0] code);
    return (code > 3'd3) ? LEN_W'(32) : LEN_W'(4 << code);
  endfunction
endpackage

// File: rtl/mcdf_arb_sel.sv
// mcdf_arb_sel: combinational winner select among enabled, non-empty channels
//   i_en/i_valid/i_prio : per-channel enable, FIFO non-empty, priority (0 = highest)
//   i_last_id           : search for equal-priority ties starts at (i_last_id + 1) mod CH_N
//   o_hit/o_id          : some channel is eligible / winning channel index
module mcdf_arb_sel
  import mcdf_arb_pkg::*;
(
  input  logic [CH_N-1:0]             i_en,
  input  logic [CH_N-1:0]             i_valid,
  input  logic [CH_N-1:0][PRIO_W-1:0] i_prio,
  input  logic [ID_W-1:0]             i_last_id,
  output logic                        o_hit,
  output logic [ID_W-1:0]             o_id
);
  logic [CH_N-1:0]   w_elig;
  logic [PRIO_W-1:0] w_min;
  logic [ID_W-1:0]   w_idx;
  logic              w_found;
  assign w_elig = i_en & i_valid;
  assign o_hit  = |w_elig;
  always_comb begin
    w_min   = '1;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < CH_N; k++)
      w_min = (w_elig[k] && i_prio[k] < w_min) ? i_prio[k] : w_min;
    // first eligible channel at the best priority, scanning from the rotated start point
    for (int k = 0; k < CH_N; k++) begin
      w_idx = ID_W'((int'(i_last_id) + 1 + k) % CH_N);
      if (!w_found && w_elig[w_idx] && i_prio[w_idx] == w_min) begin
        o_id    = w_idx;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mcdf_pkt_arbiter.sv
// mcdf_pkt_arbiter: picks a channel by priority, requests the formatter, streams one packet of pkglen words
//   clk_i, rstn_i                : clock, asynchronous active-low reset
//   slvN_en/prio/pkglen_i        : per-channel control fields (N = 0..2)
//   slvN_valid_i/data_i/ready_o  : per-channel FIFO head and pop strobe
//   fmt_req_o/grant_i/id_o/len_o : packet request handshake to the formatter
//   fmt_valid/data/ready/end     : beat stream to the formatter
// Build option: ARB_ROUND_ROBIN_EN rotates the tie-break among equal-priority channels.
module mcdf_pkt_arbiter
  import mcdf_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  slv0_en_i,
  input  logic [PRIO_W-1:0]     slv0_prio_i,
  input  logic [LEN_CODE_W-1:0] slv0_pkglen_i,
  input  logic                  slv0_valid_i,
  input  logic [DATA_W-1:0]     slv0_data_i,
  output logic                  slv0_ready_o,
  input  logic                  slv1_en_i,
  input  logic [PRIO_W-1:0]     slv1_prio_i,
  input  logic [LEN_CODE_W-1:0] slv1_pkglen_i,
  input  logic                  slv1_valid_i,
  input  logic [DATA_W-1:0]     slv1_data_i,
  output logic                  slv1_ready_o,
  input  logic                  slv2_en_i,
  input  logic [PRIO_W-1:0]     slv2_prio_i,
  input  logic [LEN_CODE_W-1:0] slv2_pkglen_i,
  input  logic                  slv2_valid_i,
  input  logic [DATA_W-1:0]     slv2_data_i,
  output logic                  slv2_ready_o,
  output logic                  fmt_req_o,
  input  logic                  fmt_grant_i,
  output logic [ID_W-1:0]       fmt_id_o,
  output logic [LEN_W-1:0]      fmt_len_o,
  output logic                  fmt_valid_o,
  output logic [DATA_W-1:0]     fmt_data_o,
  input  logic                  fmt_ready_i,
  output logic                  fmt_end_o
);
  logic [CH_N-1:0]                 w_en, w_valid;
  logic [CH_N-1:0][PRIO_W-1:0]     w_prio;
  logic [CH_N-1:0][LEN_CODE_W-1:0] w_pkglen;
  logic [CH_N-1:0][DATA_W-1:0]     w_data;
  state_t                          r_state, w_next;
  logic [ID_W-1:0]                 r_id, w_sel_id, w_last_id;
  logic [LEN_W-1:0]                r_len;
  logic [LEN_W-2:0]                r_cnt;
  logic                            w_hit, w_xfer, w_pop, w_last;
  assign w_en     = {slv2_en_i, slv1_en_i, slv0_en_i};
  assign w_valid  = {slv2_valid_i, slv1_valid_i, slv0_valid_i};
  assign w_prio   = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign w_pkglen = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};
  assign w_data   = {slv2_data_i, slv1_data_i, slv0_data_i};
  mcdf_arb_sel u_sel (
    .i_en      (w_en),
    .i_valid   (w_valid),
    .i_prio    (w_prio),
    .i_last_id (w_last_id),
    .o_hit     (w_hit),
    .o_id      (w_sel_id)
  );
`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_last;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_last <= ID_W'(2);
    else if (r_state == IDLE && w_hit) r_last <= w_sel_id;
  assign w_last_id = r_last;
`else
  // a start point after channel 2 scans from channel 0, i.e. lowest index wins ties
  assign w_last_id = ID_W'(2);
`endif
  assign w_xfer = r_state == XFER;
  assign w_pop  = w_xfer & fmt_ready_i & w_valid[r_id];
  assign w_last = {1'b0, r_cnt} == r_len - LEN_W'(1);
  always_comb begin
    w_next = (r_state == IDLE && w_hit)         ? REQ  :
             (r_state == REQ && fmt_grant_i)    ? XFER :
             (w_xfer && w_pop && w_last)        ? IDLE : r_state;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_hit) begin
        r_id  <= w_sel_id;
        r_len <= len_decode(w_pkglen[w_sel_id]);
      end
      if (w_pop) r_cnt <= w_last ? '0 : r_cnt + 5'd1;
    end
  assign fmt_req_o    = r_state == REQ;
  assign fmt_id_o     = r_id;
  assign fmt_len_o    = r_len;
  assign fmt_valid_o  = w_xfer & w_valid[r_id];
  assign fmt_data_o   = w_xfer ? w_data[r_id] : '0;
  assign fmt_end_o    = w_xfer & w_last;
  assign slv0_ready_o = w_pop & (r_id == ID_W'(0));
  assign slv1_ready_o = w_pop & (r_id == ID_W'(1));
  assign slv2_ready_o = w_pop & (r_id == ID_W'(2));
endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// tb_mcdf_pkt_arbiter: directed stimulus with a packet-level reference model checked every cycle
module tb_mcdf_pkt_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  en = '0, valid = '0;
  logic [1:0]  prio [3] = '{2'd0, 2'd0, 2'd0};
  logic [2:0]  pkglen [3] = '{3'd0, 3'd0, 3'd0};
  logic [31:0] data [3] = '{32'h0, 32'h0, 32'h0};
  logic        man_grant = 1'b0, auto_g = 1'b0, fmt_ready = 1'b0;
  logic        g_in, rdy0, rdy1, rdy2;
  logic [2:0]  rdy;
  logic        fmt_req_o, fmt_valid_o, fmt_end_o;
  logic [1:0]  fmt_id_o;
  logic [5:0]  fmt_len_o;
  logic [31:0] fmt_data_o;
  int n_tests = 0, n_fail = 0;
  int m_phase, m_id, m_len, m_done, m_last, lg_beats;
  int pops [3];
  int q_id [$];
  int q_beats [$];
  int lens [8] = '{4, 8, 16, 32, 32, 32, 32, 32};
  assign g_in = man_grant | (auto_g & fmt_req_o);
  assign rdy  = {rdy2, rdy1, rdy0};
  always #5 clk = ~clk;
  mcdf_pkt_arbiter dut (
    .clk_i(clk), .rstn_i(rstn),
    .slv0_en_i(en[0]), .slv0_prio_i(prio[0]), .slv0_pkglen_i(pkglen[0]),
    .slv0_valid_i(valid[0]), .slv0_data_i(data[0]), .slv0_ready_o(rdy0),
    .slv1_en_i(en[1]), .slv1_prio_i(prio[1]), .slv1_pkglen_i(pkglen[1]),
    .slv1_valid_i(valid[1]), .slv1_data_i(data[1]), .slv1_ready_o(rdy1),
    .slv2_en_i(en[2]), .slv2_prio_i(prio[2]), .slv2_pkglen_i(pkglen[2]),
    .slv2_valid_i(valid[2]), .slv2_data_i(data[2]), .slv2_ready_o(rdy2),
    .fmt_req_o(fmt_req_o), .fmt_grant_i(g_in), .fmt_id_o(fmt_id_o), .fmt_len_o(fmt_len_o),
    .fmt_valid_o(fmt_valid_o), .fmt_data_o(fmt_data_o), .fmt_ready_i(fmt_ready), .fmt_end_o(fmt_end_o)
  );
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  // best = smallest (priority, rotated position) key among eligible channels
  function automatic int pick();
    int best = -1, bkey = 99, key;
    for (int k = 0; k < 3; k++)
      if (en[k] && valid[k]) begin
        key = int'(prio[k]) * 4 + (RR ? (k - m_last + 2) % 3 : k);
        if (key < bkey) begin
          bkey = key;
          best = k;
        end
      end
    return best;
  endfunction
  // inputs are stable from posedge+1 to the next posedge, so the negedge sees what the next edge will use
  always @(negedge clk) begin
    int w;
    logic e_valid;
    if (!rstn) begin
      m_phase = 0; m_id = 0; m_len = 0; m_done = 0; m_last = 2; lg_beats = 0;
      pops = '{0, 0, 0};
    end
    e_valid = m_phase == 2 && valid[m_id];
    chk("req", 32'(fmt_req_o), 32'(m_phase == 1));
    chk("id", 32'(fmt_id_o), 32'(m_id));
    chk("len", 32'(fmt_len_o), 32'(m_len));
    chk("valid", 32'(fmt_valid_o), 32'(e_valid));
    if (e_valid) begin
      chk("data", fmt_data_o, data[m_id]);
      chk("end", 32'(fmt_end_o), 32'(m_done == m_len - 1));
    end
    for (int k = 0; k < 3; k++)
      chk("ready", 32'(rdy[k]), 32'(m_phase == 2 && m_id == k && valid[k] && fmt_ready));
    if (rstn) begin
      for (int k = 0; k < 3; k++) if (rdy[k]) pops[k]++;
      if (fmt_valid_o && fmt_ready) begin
        lg_beats++;
        if (fmt_end_o) begin
          q_id.push_back(int'(fmt_id_o));
          q_beats.push_back(lg_beats);
          lg_beats = 0;
        end
      end
      case (m_phase)
        0: begin
          w = pick();
          if (w >= 0) begin
            m_id = w; m_len = lens[pkglen[w]]; m_done = 0; m_last = w; m_phase = 1;
          end
        end
        1: if (g_in) m_phase = 2;
        default: if (valid[m_id] && fmt_ready) begin
          m_done++;
          if (m_done == m_len) m_phase = 0;
        end
      endcase
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) data[k] = $urandom;
  endtask
  task automatic wait_pkts(int n);
    int t = 0;
    while (q_id.size() < n && t < 600) begin
      step();
      t++;
    end
    chk("pkt_timeout", 32'(q_id.size() >= n), 32'd1);
  endtask
  task automatic do_reset();
    en = '0; valid = '0; man_grant = 0; auto_g = 0; fmt_ready = 0;
    prio = '{2'd0, 2'd0, 2'd0}; pkglen = '{3'd0, 3'd0, 3'd0};
    rstn = 0;
    step();
    step();
    rstn = 1;
    q_id.delete();
    q_beats.delete();
  endtask
  initial begin
    int drop;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(fmt_req_o), 0);
    chk("rst_len", 32'(fmt_len_o), 0);
    chk("rst_ready", 32'(rdy), 0);
    step();
    rstn = 1;
    repeat (3) step();
    @(negedge clk);
    chk("idle_req", 32'(fmt_req_o), 0);
    // ch1 alone, 4-word packet, grant withheld for 3 cycles
    en[1] = 1; valid[1] = 1; fmt_ready = 1;
    step();
    repeat (3) begin
      @(negedge clk);
      chk("hold_req", 32'(fmt_req_o), 1);
      chk("hold_len", 32'(fmt_len_o), 4);
      step();
    end
    man_grant = 1;
    step();
    man_grant = 0;
    wait_pkts(1);
    chk("c1_id", 32'(q_id[0]), 1);
    chk("c1_beats", 32'(q_beats[0]), 4);
    chk("c1_pops", 32'(pops[1]), 4);
    // priority: ch2 (prio 1) beats ch0 (prio 2), then ch0
    do_reset();
    en = 3'b101; valid = 3'b101; prio[0] = 2; prio[2] = 1; auto_g = 1; fmt_ready = 1;
    wait_pkts(1);
    valid[2] = 0;
    wait_pkts(2);
    chk("prio_first", 32'(q_id[0]), 2);
    chk("prio_second", 32'(q_id[1]), 0);
    // equal priorities: fixed or rotating tie-break
    do_reset();
    en = 3'b111; valid = 3'b111; auto_g = 1; fmt_ready = 1;
    wait_pkts(3);
    for (int k = 0; k < 3; k++) chk("tie_id", 32'(q_id[k]), RR ? 32'(k) : 0);
    // 32-word packet with a source stall and a toggling formatter ready
    do_reset();
    en[0] = 1; valid[0] = 1; pkglen[0] = 3; auto_g = 1;
    drop = 0;
    for (int c = 0; c < 400 && q_id.size() == 0; c++) begin
      fmt_ready = c % 2 == 0;
      if (lg_beats >= 9 && drop < 3) begin
        valid[0] = 0;
        drop++;
      end else valid[0] = 1;
      step();
    end
    auto_g = 0;
    chk("long_done", 32'(q_id.size()), 1);
    chk("long_beats", 32'(q_beats[0]), 32);
    chk("long_pops", 32'(pops[0]), 32);
    // saturated length code, control changes mid-packet ignored
    do_reset();
    en[1] = 1; valid[1] = 1; pkglen[1] = 6; fmt_ready = 1;
    step();
    @(negedge clk);
    chk("sat_len", 32'(fmt_len_o), 32);
    man_grant = 1;
    step();
    man_grant = 0;
    repeat (5) step();
    pkglen[1] = 0; en[1] = 0; prio[1] = 3;
    wait_pkts(1);
    chk("sat_beats", 32'(q_beats[0]), 32);
    // reset in the middle of a transfer
    en[1] = 1; pkglen[1] = 1;
    step();
    man_grant = 1;
    step();
    man_grant = 0;
    repeat (3) step();
    @(negedge clk);
    chk("mid_valid", 32'(fmt_valid_o), 1);
    step();
    rstn = 0;
    @(negedge clk);
    chk("rstx_valid", 32'(fmt_valid_o), 0);
    chk("rstx_id", 32'(fmt_id_o), 0);
    chk("rstx_len", 32'(fmt_len_o), 0);
    chk("rstx_ready", 32'(rdy), 0);
    step();
    en = '0; rstn = 1;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
